// File: rtl/uart_pkt_loader.sv
// uart_pkt_loader
//
// Turns the UART receive byte stream into framed, checksummed write packets
// for a 16-entry byte register file, then answers each packet with a single
// ACK or NAK byte through the UART transmitter.
//
// Packet: SYNC, HDR, payload[0..N-1], CSUM
//   HDR[7:4] = start address A, HDR[3:0] = N-1 (N = 1..16)
//   CSUM     = HDR ^ payload[0] ^ ... ^ payload[N-1]
// The payload is staged and only written to the register file once the
// checksum has matched, so a bad packet never touches the register file.
//
// Optional build macro: UART_PKT_LOADER_TIMEOUT_EN
//   When defined, a packet that stalls for TIMEOUT_CYCLES clocks between
//   bytes is abandoned and answered with NAK. When undefined the loader
//   waits indefinitely mid-packet.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_rdy, rx_data       UART receive byte available / byte value
//   rx_rdy_clr            one-cycle pulse consuming the received byte
//   tx_busy               UART transmitter busy
//   tx_din, tx_wr_en      response byte and one-cycle transmit strobe
//   mem_we, mem_addr,
//   mem_wdata             register-file write port
//   busy                  high whenever the loader is not in IDLE
//   ok_cnt, err_cnt       wrapping counts of good and bad/aborted packets

module uart_pkt_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_rdy_clr,
  input  logic       tx_busy,
  output logic [7:0] tx_din,
  output logic       tx_wr_en,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic [7:0] ok_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    COMMIT  = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state_reg, state_next;

  logic [3:0]  addr_reg;       // start address A
  logic [3:0]  last_reg;       // N-1
  logic [3:0]  idx_reg;        // payload index while receiving, write index j in COMMIT
  logic [7:0]  csum_reg;       // running checksum
  logic [7:0]  ok_cnt_reg;
  logic [7:0]  err_cnt_reg;
  logic [7:0]  tx_din_reg;
  logic        rx_rdy_clr_reg;

  logic [7:0]  stage [16];     // payload staging buffer, no reset needed

  logic        take;           // a byte is consumed this cycle
  logic        in_pkt;         // mid-packet receive states
  logic        ack_now;
  logic        nak_now;
  logic        tmo_hit;

  // A byte is only taken when the previous clear pulse is not in flight,
  // which limits consumption to one byte every two cycles.
  assign in_pkt = (state_reg == HDR) || (state_reg == PAYLOAD) || (state_reg == CSUM);
  assign take   = rx_rdy && !rx_rdy_clr_reg && ((state_reg == IDLE) || in_pkt);

`ifdef UART_PKT_LOADER_TIMEOUT_EN
  logic [15:0] tmo_reg;

  // Counts idle cycles between bytes of a packet; idle outside the packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_reg <= 16'd0;
    end else if (in_pkt && !take) begin
      tmo_reg <= tmo_reg + 16'd1;
    end else begin
      tmo_reg <= 16'd0;
    end
  end

  // A byte arriving on the expiry cycle still wins over the abort.
  assign tmo_hit = in_pkt && !take && (tmo_reg == TIMEOUT_CYCLES);
`else
  // Timeout parameter stays in the interface so both builds instantiate
  // identically; without the feature it has no effect.
  assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 16'd0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and combinational outputs
  always_comb begin
    state_next = state_reg;
    ack_now    = 1'b0;
    nak_now    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 4'd0;
    mem_wdata  = 8'd0;
    tx_wr_en   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (take && (rx_data == SYNC_BYTE)) begin
          state_next = HDR;
        end
      end
      HDR: begin
        if (take) begin
          state_next = PAYLOAD;
        end else if (tmo_hit) begin
          nak_now    = 1'b1;
          state_next = RESP;
        end
      end
      PAYLOAD: begin
        if (take) begin
          if (idx_reg == last_reg) begin
            state_next = CSUM;
          end
        end else if (tmo_hit) begin
          nak_now    = 1'b1;
          state_next = RESP;
        end
      end
      CSUM: begin
        if (take) begin
          if (rx_data == csum_reg) begin
            state_next = COMMIT;
          end else begin
            nak_now    = 1'b1;
            state_next = RESP;
          end
        end else if (tmo_hit) begin
          nak_now    = 1'b1;
          state_next = RESP;
        end
      end
      COMMIT: begin
        mem_we    = 1'b1;
        mem_addr  = addr_reg + idx_reg;  // 4-bit add wraps modulo 16
        mem_wdata = stage[idx_reg];
        if (idx_reg == last_reg) begin
          ack_now    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (!tx_busy) begin
          tx_wr_en   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg       <= 4'd0;
      last_reg       <= 4'd0;
      idx_reg        <= 4'd0;
      csum_reg       <= 8'd0;
      ok_cnt_reg     <= 8'd0;
      err_cnt_reg    <= 8'd0;
      tx_din_reg     <= 8'd0;
      rx_rdy_clr_reg <= 1'b0;
    end else begin
      rx_rdy_clr_reg <= take;

      if (take) begin
        case (state_reg)
          HDR: begin
            addr_reg <= rx_data[7:4];
            last_reg <= rx_data[3:0];
            csum_reg <= rx_data;
            idx_reg  <= 4'd0;
          end
          PAYLOAD: begin
            csum_reg <= csum_reg ^ rx_data;
            idx_reg  <= idx_reg + 4'd1;
          end
          CSUM: begin
            idx_reg <= 4'd0;  // restart as the commit write index
          end
          default: begin
          end
        endcase
      end

      if ((state_reg == COMMIT) && (idx_reg != last_reg)) begin
        idx_reg <= idx_reg + 4'd1;
      end

      // Response byte is loaded on entry to RESP and then held.
      if (ack_now) begin
        ok_cnt_reg <= ok_cnt_reg + 8'd1;
        tx_din_reg <= ACK_BYTE;
      end
      if (nak_now) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
        tx_din_reg  <= NAK_BYTE;
      end
    end
  end

  // Staging buffer write
  always_ff @(posedge clk) begin
    if (take && (state_reg == PAYLOAD)) begin
      stage[idx_reg] <= rx_data;
    end
  end

  assign rx_rdy_clr = rx_rdy_clr_reg;
  assign tx_din     = tx_din_reg;
  assign busy       = (state_reg != IDLE);
  assign ok_cnt     = ok_cnt_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_uart_pkt_loader.sv
// Directed testbench for uart_pkt_loader (default build, timeout disabled).
// A small UART-side model presents bytes and drops rx_rdy on rx_rdy_clr;
// a monitor records register-file writes and transmit strobes.

module tb_uart_pkt_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       tx_busy = 1'b0;
  logic       rx_rdy_clr;
  logic [7:0] tx_din;
  logic       tx_wr_en;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic [7:0] ok_cnt;
  logic [7:0] err_cnt;

  uart_pkt_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .tx_busy    (tx_busy),
    .tx_din     (tx_din),
    .tx_wr_en   (tx_wr_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .ok_cnt     (ok_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         wr_cyc_q  [$];
  int         tx_cnt = 0;
  logic [7:0] tx_last = 8'd0;
  int         clr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (tx_wr_en) begin
        tx_cnt  = tx_cnt + 1;
        tx_last = tx_din;
      end
      if (rx_rdy_clr) clr_cnt = clr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    @(posedge clk); #2;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(posedge clk); #2;
      if (rx_rdy_clr) done = 1'b1;
    end
    rx_rdy = 1'b0;
    if (!done) chk("rx_consumed", {31'd0, done}, 32'd1);
  endtask

  task automatic send_pkt(input logic [7:0] bytes [$]);
    foreach (bytes[k]) send_byte(bytes[k]);
  endtask

  task automatic wait_tx(input string tag, input int exp_cnt, input logic [7:0] exp_byte);
    for (int n = 0; n < 200 && tx_cnt < exp_cnt; n++) @(posedge clk);
    @(posedge clk); #2;
    chk({tag, "_tx_pulses"}, tx_cnt, exp_cnt);
    chk({tag, "_tx_byte"}, {24'd0, tx_last}, {24'd0, exp_byte});
  endtask

  task automatic check_wr(input string tag, input logic [3:0] a, input int n,
                          input logic [7:0] d [16]);
    chk({tag, "_wr_count"}, wr_addr_q.size(), n);
    if (wr_addr_q.size() == n && n > 0) begin
      for (int j = 0; j < n; j++) begin
        chk($sformatf("%s_wr%0d_addr", tag, j), {28'd0, wr_addr_q[j]}, {28'd0, a + 4'(j)});
        chk($sformatf("%s_wr%0d_data", tag, j), {24'd0, wr_data_q[j]}, {24'd0, d[j]});
      end
      chk({tag, "_wr_consecutive"}, wr_cyc_q[n-1] - wr_cyc_q[0], n - 1);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},       {31'd0, busy},       32'd0);
    chk({tag, "_ok_cnt"},     {24'd0, ok_cnt},     32'd0);
    chk({tag, "_err_cnt"},    {24'd0, err_cnt},    32'd0);
    chk({tag, "_tx_din"},     {24'd0, tx_din},     32'd0);
    chk({tag, "_tx_wr_en"},   {31'd0, tx_wr_en},   32'd0);
    chk({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
    chk({tag, "_mem_addr"},   {28'd0, mem_addr},   32'd0);
    chk({tag, "_mem_wdata"},  {24'd0, mem_wdata},  32'd0);
    chk({tag, "_rx_rdy_clr"}, {31'd0, rx_rdy_clr}, 32'd0);
  endtask

  logic [7:0] d [16];
  int         tx_before;
  int         clr_before;
  bit         got_clr;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Good packet: A=3, N=3, checksum 32^11^22^33 = 32
    send_pkt('{8'hA5, 8'h32, 8'h11, 8'h22, 8'h33, 8'h32});
    wait_tx("t1", 1, 8'h06);
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    check_wr("t1", 4'h3, 3, d);
    chk("t1_ok_cnt", {24'd0, ok_cnt}, 32'd1);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Address wrap: A=E, N=4, checksum E3^01^02^03^04 = E7
    send_pkt('{8'hA5, 8'hE3, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE7});
    wait_tx("t2", 2, 8'h06);
    d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03; d[3] = 8'h04;
    check_wr("t2", 4'hE, 4, d);
    chk("t2_ok_cnt", {24'd0, ok_cnt}, 32'd2);

    // Bad checksum: expected 55, sent 00
    send_pkt('{8'hA5, 8'h00, 8'h55, 8'h00});
    wait_tx("t3", 3, 8'h15);
    check_wr("t3", 4'h0, 0, d);
    chk("t3_err_cnt", {24'd0, err_cnt}, 32'd1);
    chk("t3_ok_cnt", {24'd0, ok_cnt}, 32'd2);

    // Transmitter busy: A=0, N=2, checksum 01^AA^BB = 10
    @(posedge clk); #2;
    tx_busy = 1'b1;
    send_pkt('{8'hA5, 8'h01, 8'hAA, 8'hBB, 8'h10});
    repeat (20) @(posedge clk);
    #2;
    chk("t5_in_resp_busy", {31'd0, busy}, 32'd1);
    rx_data    = 8'h00;
    rx_rdy     = 1'b1;
    tx_before  = tx_cnt;
    clr_before = clr_cnt;
    repeat (100) @(posedge clk);
    #2;
    chk("t5_no_tx_while_busy", tx_cnt, tx_before);
    chk("t5_rx_left_pending", clr_cnt, clr_before);
    chk("t5_still_busy", {31'd0, busy}, 32'd1);
    tx_busy = 1'b0;
    #1;
    chk("t5_tx_wr_en_on_release", {31'd0, tx_wr_en}, 32'd1);
    chk("t5_tx_din", {24'd0, tx_din}, 32'h06);
    got_clr = 1'b0;
    for (int n = 0; n < 20 && !got_clr; n++) begin
      @(posedge clk); #2;
      if (rx_rdy_clr) got_clr = 1'b1;
    end
    rx_rdy = 1'b0;
    chk("t5_pending_byte_consumed", {31'd0, got_clr}, 32'd1);
    chk("t5_single_tx_pulse", tx_cnt, tx_before + 1);
    d[0] = 8'hAA; d[1] = 8'hBB;
    check_wr("t5", 4'h0, 2, d);
    chk("t5_ok_cnt", {24'd0, ok_cnt}, 32'd3);

    // Leading junk then a full 16-byte packet: data 10..1F, checksum 0F
    send_pkt('{8'h00, 8'h7F});
    chk("t4_junk_err_cnt", {24'd0, err_cnt}, 32'd1);
    chk("t4_junk_idle", {31'd0, busy}, 32'd0);
    send_byte(8'hA5);
    send_byte(8'h0F);
    for (int j = 0; j < 16; j++) begin
      d[j] = 8'h10 + 8'(j);
      send_byte(d[j]);
    end
    send_byte(8'h0F);
    wait_tx("t4", 5, 8'h06);
    check_wr("t4", 4'h0, 16, d);
    chk("t4_ok_cnt", {24'd0, ok_cnt}, 32'd4);
    chk("t4_err_cnt", {24'd0, err_cnt}, 32'd1);

    // Reset in the middle of the payload
    send_pkt('{8'hA5, 8'h03, 8'h01, 8'h02});
    @(posedge clk); #2;
    tx_before = tx_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    chk("midrst_no_tx", tx_cnt, tx_before);
    chk("midrst_no_writes", wr_addr_q.size(), 0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);

    // Recovery after reset: A=1, N=1, checksum 10^77 = 67
    send_pkt('{8'hA5, 8'h10, 8'h77, 8'h67});
    wait_tx("rec", tx_before + 1, 8'h06);
    d[0] = 8'h77;
    check_wr("rec", 4'h1, 1, d);
    chk("rec_ok_cnt", {24'd0, ok_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
